// File: rtl/if_stage_req_pkg.sv
// Shared defaults and width helpers for the instruction-fetch stage.
package if_stage_req_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_INST_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

    function automatic int fs_to_ds_wd(input int addr_w, input int inst_w);
        return addr_w + inst_w + 1;
    endfunction

    function automatic int br_to_fs_wd(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_stage_req_if.sv
// Split request/response instruction-SRAM bus between the fetch stage and memory.
interface if_stage_req_if
    import if_stage_req_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W
) ();

    logic              inst_sram_req;
    logic [ADDR_W-1:0] inst_sram_addr;
    logic              inst_sram_addr_ok;
    logic              inst_sram_data_ok;
    logic [INST_W-1:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

endinterface

// File: rtl/if_stage_req_sync_fifo.sv
// Small synchronous FIFO with occupancy count; clear empties it in one cycle.
module if_sync_fifo
    import if_stage_req_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     clear,
    output logic [W-1:0]             dout,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign full    = (32'(count) == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_stage_req.sv
// Instruction-fetch stage: issues pipelined SRAM requests, cancels stale responses
// after a redirect and buffers {adef, pc, inst} for ID.
module if_stage_req
    import if_stage_req_pkg::*;
#(
    parameter int                ADDR_W         = DEF_ADDR_W,
    parameter int                INST_W         = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEF_RESET_PC),
    parameter int                MAX_OUT        = 2,
    parameter int                INST_BUF_DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [br_to_fs_wd(ADDR_W)-1:0]          br_bus,
    input  logic                                    flush,
    input  logic [ADDR_W-1:0]                       flush_pc,
    input  logic                                    ds_allow_in,
    if_stage_req_if.master                          sram,
    output logic                                    fs_to_ds_valid,
    output logic [fs_to_ds_wd(ADDR_W, INST_W)-1:0]  fs_to_ds_bus
);

    localparam int FS_TO_DS_WD = fs_to_ds_wd(ADDR_W, INST_W);
    localparam int TCW         = cnt_w(MAX_OUT);
    localparam int BCW         = cnt_w(INST_BUF_DEPTH);

    logic                   br_taken;
    logic [ADDR_W-1:0]      br_target;
    logic [ADDR_W-1:0]      fetch_pc;
    logic [TCW-1:0]         cancel_cnt;
    logic                   adef_stall;

    logic [TCW-1:0]         trk_count;
    logic                   trk_full;
    logic                   trk_empty;
    logic [ADDR_W-1:0]      trk_head;
    logic [BCW-1:0]         buf_count;
    logic                   buf_full;
    logic                   buf_empty;
    logic [FS_TO_DS_WD-1:0] buf_head;

    logic                   redirect;
    logic [ADDR_W-1:0]      redirect_pc;
    logic [31:0]            outstanding;
    logic                   req;
    logic                   req_fire;
    logic                   rsp_valid;
    logic                   rsp_drop;
    logic                   rsp_keep;
    logic                   adef_push;
    logic                   buf_push;
    logic                   buf_pop;
    logic [FS_TO_DS_WD-1:0] buf_din;

    assign {br_taken, br_target} = br_bus;

    // Outstanding counts live requests in the tracker plus cancelled ones still owed by the bus;
    // reserving a buffer slot per outstanding request means data_ok never finds the buffer full.
    always_comb begin
        redirect    = br_taken || flush;
        redirect_pc = flush ? flush_pc : br_target;
        outstanding = 32'(trk_count) + 32'(cancel_cnt);
        req         = resetn && !redirect && !adef_stall && (fetch_pc[1:0] == 2'b00) && !trk_full
                      && (outstanding < 32'(MAX_OUT))
                      && ((outstanding + 32'(buf_count)) < 32'(INST_BUF_DEPTH));
        req_fire    = req && sram.inst_sram_addr_ok;
        rsp_valid   = resetn && sram.inst_sram_data_ok && (outstanding != 32'd0);
        rsp_drop    = rsp_valid && (cancel_cnt != '0);
        rsp_keep    = rsp_valid && (cancel_cnt == '0) && !trk_empty;
        adef_push   = resetn && !redirect && !adef_stall && (fetch_pc[1:0] != 2'b00)
                      && (outstanding == 32'd0) && !buf_full;
        buf_push    = (rsp_keep || adef_push) && !redirect;
        buf_din     = adef_push ? {1'b1, fetch_pc, {INST_W{1'b0}}}
                                : {1'b0, trk_head, sram.inst_sram_rdata};
        buf_pop     = fs_to_ds_valid && ds_allow_in;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc   <= RESET_PC;
            cancel_cnt <= '0;
            adef_stall <= 1'b0;
        end else if (redirect) begin
            fetch_pc   <= redirect_pc;
            cancel_cnt <= TCW'(outstanding - 32'(rsp_valid));
            adef_stall <= 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (rsp_drop) begin
                cancel_cnt <= cancel_cnt - TCW'(1);
            end
            if (adef_push) begin
                adef_stall <= 1'b1;
            end
        end
    end

    if_sync_fifo #(.W(ADDR_W), .DEPTH(MAX_OUT)) u_pc_tracker (
        .clk    (clk),
        .resetn (resetn),
        .push   (req_fire),
        .din    (fetch_pc),
        .pop    (rsp_keep),
        .clear  (redirect),
        .dout   (trk_head),
        .count  (trk_count),
        .full   (trk_full),
        .empty  (trk_empty)
    );

    if_sync_fifo #(.W(FS_TO_DS_WD), .DEPTH(INST_BUF_DEPTH)) u_inst_buf (
        .clk    (clk),
        .resetn (resetn),
        .push   (buf_push),
        .din    (buf_din),
        .pop    (buf_pop),
        .clear  (redirect),
        .dout   (buf_head),
        .count  (buf_count),
        .full   (buf_full),
        .empty  (buf_empty)
    );

    assign sram.inst_sram_req  = req;
    assign sram.inst_sram_addr = fetch_pc;
    assign fs_to_ds_valid      = !buf_empty;
    assign fs_to_ds_bus        = fs_to_ds_valid ? buf_head : '0;

    // A response with nothing in flight means the memory side broke the protocol.
    assert property (@(posedge clk) disable iff (!resetn)
        sram.inst_sram_data_ok |-> (outstanding != 32'd0));

endmodule

// File: tb/tb_if_stage_req.sv
// Directed, table-driven bench for if_stage_req: per-cycle inputs with hand-computed outputs.
module tb_if_stage_req;
    import if_stage_req_pkg::*;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [32:0] br_bus;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ds_allow_in;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;

    if_stage_req_if #(.ADDR_W(32), .INST_W(32)) sram_bus ();

    if_stage_req #(
        .ADDR_W(32), .INST_W(32), .RESET_PC(32'h1c00_0000), .MAX_OUT(2), .INST_BUF_DEPTH(4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .br_bus         (br_bus),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .ds_allow_in    (ds_allow_in),
        .sram           (sram_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        br;
        logic [31:0] br_tgt;
        logic        fl;
        logic [31:0] fl_pc;
        logic        allow;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [64:0] exp_bus;
    } vec_t;

    vec_t vecs[$];
    int   vec_count  = 0;
    int   miss_count = 0;

    function automatic logic [64:0] ent(input logic adef, input logic [31:0] pc, input logic [31:0] inst);
        return {adef, pc, inst};
    endfunction

    function automatic vec_t mk(
        input logic rstn, input logic br, input logic [31:0] br_tgt, input logic fl, input logic [31:0] fl_pc,
        input logic allow, input logic aok, input logic dok, input logic [31:0] rdata,
        input logic exp_req, input logic [31:0] exp_addr, input logic exp_valid, input logic [64:0] exp_bus);
        vec_t v;
        v.rstn = rstn;     v.br = br;           v.br_tgt = br_tgt;       v.fl = fl;
        v.fl_pc = fl_pc;   v.allow = allow;     v.aok = aok;             v.dok = dok;
        v.rdata = rdata;   v.exp_req = exp_req; v.exp_addr = exp_addr;   v.exp_valid = exp_valid;
        v.exp_bus = exp_bus;
        return v;
    endfunction

    // Plain cycle: no redirect, reset released.
    task automatic add(input logic allow, input logic aok, input logic dok, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid, input logic [64:0] e_bus);
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, allow, aok, dok, rdata, e_req, e_addr, e_valid, e_bus));
    endtask

    task automatic applyStimulus(input vec_t v);
        resetn                     = v.rstn;
        br_bus                     = {v.br, v.br_tgt};
        flush                      = v.fl;
        flush_pc                   = v.fl_pc;
        ds_allow_in                = v.allow;
        sram_bus.inst_sram_addr_ok = v.aok;
        sram_bus.inst_sram_data_ok = v.dok;
        sram_bus.inst_sram_rdata   = v.rdata;
    endtask

    task automatic checkOutput(input vec_t v, input string name, input int idx);
        if (sram_bus.inst_sram_req !== v.exp_req) begin
            miss_count++;
            $display("[TB] FAIL %s[%0d] req: got %0b expected %0b", name, idx, sram_bus.inst_sram_req, v.exp_req);
        end
        if (sram_bus.inst_sram_addr !== v.exp_addr) begin
            miss_count++;
            $display("[TB] FAIL %s[%0d] addr: got %h expected %h", name, idx, sram_bus.inst_sram_addr, v.exp_addr);
        end
        if (fs_to_ds_valid !== v.exp_valid) begin
            miss_count++;
            $display("[TB] FAIL %s[%0d] valid: got %0b expected %0b", name, idx, fs_to_ds_valid, v.exp_valid);
        end
        if (fs_to_ds_bus !== v.exp_bus) begin
            miss_count++;
            $display("[TB] FAIL %s[%0d] bus: got %h expected %h", name, idx, fs_to_ds_bus, v.exp_bus);
        end
    endtask

    task automatic runVec(input vec_t v, input string name, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, name, idx);
        vec_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic buildTable();
        // reset held: req gated, fetch_pc at reset value
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, B, 1'b0, 65'h0));
        // streaming fetch, one-cycle response latency
        add(1, 1, 0, 32'h0,         1, B + 32'h00, 0, 65'h0);
        add(1, 1, 1, 32'hd000_0000, 1, B + 32'h04, 0, 65'h0);
        add(1, 1, 1, 32'hd000_0001, 1, B + 32'h08, 1, ent(1'b0, B + 32'h00, 32'hd000_0000));
        add(1, 1, 1, 32'hd000_0002, 1, B + 32'h0c, 1, ent(1'b0, B + 32'h04, 32'hd000_0001));
        add(1, 0, 1, 32'hd000_0003, 1, B + 32'h10, 1, ent(1'b0, B + 32'h08, 32'hd000_0002));
        add(1, 0, 0, 32'h0,         1, B + 32'h10, 1, ent(1'b0, B + 32'h0c, 32'hd000_0003));
        add(1, 0, 0, 32'h0,         1, B + 32'h10, 0, 65'h0);
        // ID stalled: credit rule closes req once outstanding+buffered reaches 4
        add(0, 1, 0, 32'h0,         1, B + 32'h10, 0, 65'h0);
        add(0, 1, 1, 32'he000_0000, 1, B + 32'h14, 0, 65'h0);
        add(0, 1, 1, 32'he000_0001, 1, B + 32'h18, 1, ent(1'b0, B + 32'h10, 32'he000_0000));
        add(0, 1, 1, 32'he000_0002, 1, B + 32'h1c, 1, ent(1'b0, B + 32'h10, 32'he000_0000));
        add(0, 1, 1, 32'he000_0003, 0, B + 32'h20, 1, ent(1'b0, B + 32'h10, 32'he000_0000));
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 0, 32'h0,     0, B + 32'h20, 1, ent(1'b0, B + 32'h10, 32'he000_0000));
        end
        add(1, 0, 0, 32'h0,         0, B + 32'h20, 1, ent(1'b0, B + 32'h10, 32'he000_0000));
        add(1, 0, 0, 32'h0,         1, B + 32'h20, 1, ent(1'b0, B + 32'h14, 32'he000_0001));
        add(1, 0, 0, 32'h0,         1, B + 32'h20, 1, ent(1'b0, B + 32'h18, 32'he000_0002));
        add(1, 0, 0, 32'h0,         1, B + 32'h20, 1, ent(1'b0, B + 32'h1c, 32'he000_0003));
        add(1, 0, 0, 32'h0,         1, B + 32'h20, 0, 65'h0);
        // branch with two requests in flight: both responses dropped
        add(1, 1, 0, 32'h0,         1, B + 32'h20, 0, 65'h0);
        add(1, 1, 0, 32'h0,         1, B + 32'h24, 0, 65'h0);
        vecs.push_back(mk(1, 1, B + 32'h100, 0, 32'h0, 1, 1, 0, 32'h0, 0, B + 32'h28, 0, 65'h0));
        add(1, 1, 1, 32'hf000_0000, 0, B + 32'h100, 0, 65'h0);
        add(1, 1, 1, 32'hf000_0001, 1, B + 32'h100, 0, 65'h0);
        add(1, 0, 1, 32'hf000_0002, 1, B + 32'h104, 0, 65'h0);
        add(1, 0, 0, 32'h0,         1, B + 32'h104, 1, ent(1'b0, B + 32'h100, 32'hf000_0002));
        // flush to a misaligned pc: one adef entry, then fetch stays parked
        vecs.push_back(mk(1, 0, 32'h0, 1, B + 32'h102, 1, 0, 0, 32'h0, 0, B + 32'h104, 0, 65'h0));
        add(1, 0, 0, 32'h0,         0, B + 32'h102, 0, 65'h0);
        add(1, 0, 0, 32'h0,         0, B + 32'h102, 1, ent(1'b1, B + 32'h102, 32'h0));
        add(1, 1, 0, 32'h0,         0, B + 32'h102, 0, 65'h0);
        add(1, 1, 0, 32'h0,         0, B + 32'h102, 0, 65'h0);
        // branch in the same cycle as the only outstanding response
        vecs.push_back(mk(1, 1, B + 32'h200, 0, 32'h0, 1, 0, 0, 32'h0, 0, B + 32'h102, 0, 65'h0));
        add(1, 1, 0, 32'h0,         1, B + 32'h200, 0, 65'h0);
        vecs.push_back(mk(1, 1, B + 32'h300, 0, 32'h0, 1, 1, 1, 32'h9000_0000, 0, B + 32'h204, 0, 65'h0));
        add(1, 1, 0, 32'h0,         1, B + 32'h300, 0, 65'h0);
        add(1, 0, 1, 32'h9000_0001, 1, B + 32'h304, 0, 65'h0);
        add(1, 0, 0, 32'h0,         1, B + 32'h304, 1, ent(1'b0, B + 32'h300, 32'h9000_0001));
        // branch and flush together: flush target wins
        vecs.push_back(mk(1, 1, B + 32'h500, 1, B + 32'h600, 1, 0, 0, 32'h0, 0, B + 32'h304, 0, 65'h0));
        add(1, 0, 0, 32'h0,         1, B + 32'h600, 0, 65'h0);
    endtask

    // Fetch across the top of the address space.
    task automatic wrapSequence();
        runVec(mk(1, 1, 32'hffff_fffc, 0, 32'h0, 1, 0, 0, 32'h0, 0, B + 32'h600, 0, 65'h0), "wrap", 0);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0,         1, 32'hffff_fffc, 0, 65'h0), "wrap", 1);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 0, 1, 32'h4b4b_0000, 1, 32'h0000_0000, 0, 65'h0), "wrap", 2);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1,
                  ent(1'b0, 32'hffff_fffc, 32'h4b4b_0000)), "wrap", 3);
    endtask

    // Reset with two requests in flight and two entries buffered.
    task automatic resetSequence();
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0,         1, 32'h00, 0, 65'h0), "rst", 0);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h8000_0000, 1, 32'h04, 0, 65'h0), "rst", 1);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h8000_0001, 1, 32'h08, 1,
                  ent(1'b0, 32'h00, 32'h8000_0000)), "rst", 2);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0,         1, 32'h0c, 1,
                  ent(1'b0, 32'h00, 32'h8000_0000)), "rst", 3);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0,         0, 32'h10, 1,
                  ent(1'b0, 32'h00, 32'h8000_0000)), "rst", 4);
        runVec(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0,         0, 32'h10, 1,
                  ent(1'b0, 32'h00, 32'h8000_0000)), "rst", 5);
        runVec(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0,         0, B, 0, 65'h0), "rst", 6);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0,         1, B, 0, 65'h0), "rst", 7);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 0, 1, 32'h1234_5678, 1, B + 32'h4, 0, 65'h0), "rst", 8);
        runVec(mk(1, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0,         1, B + 32'h4, 1,
                  ent(1'b0, B, 32'h1234_5678)), "rst", 9);
    endtask

    initial begin
        resetn                     = 1'b0;
        br_bus                     = '0;
        flush                      = 1'b0;
        flush_pc                   = '0;
        ds_allow_in                = 1'b0;
        sram_bus.inst_sram_addr_ok = 1'b0;
        sram_bus.inst_sram_data_ok = 1'b0;
        sram_bus.inst_sram_rdata   = '0;
        buildTable();
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            runVec(vecs[i], "table", i);
        end
        wrapSequence();
        resetSequence();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
